vga_timing_gen: RTL

- Parametrised VGA raster timing generator, the successor to the team's fixed 640x480 timing block.
- Resolution, porches, sync polarity and counter widths are set by parameters.
- Sync, data-enable and x/y outputs pass through a configurable pixel-tick delay pipeline, so they line up with renderer latency.
- Provides one-clk event strobes (line_start, frame_start, vblank_start) and a frame counter.
- Sits between the pixel-enable divider and the sprite/renderer logic and VGA pins.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync/de decode through a
// pix_en-gated delay pipeline, registered undelayed event strobes and a frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned PIPE_DLY = 1,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_count
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_BEGIN + H_SYNC;
    localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_BEGIN + V_SYNC;

    // Sync bits are stored as "asserted" flags; polarity is applied at the output.
    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           de;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } stage_t;

    logic [X_W-1:0]     h_q, h_d;
    logic [Y_W-1:0]     v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [31:0]        h_ext, v_ext;
    logic               de_raw;
    stage_t             raw;
    stage_t             pipe_q [PIPE_DLY];
    logic               line_q, frame_start_q, vblank_q;

    assign h_ext  = 32'(h_q);
    assign v_ext  = 32'(v_q);
    assign de_raw = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);

    always_comb begin
        h_d     = h_q + X_W'(1);
        v_d     = v_q;
        frame_d = frame_q;
        if (h_ext == H_TOTAL - 1) begin
            h_d = '0;
            if (v_ext == V_TOTAL - 1) begin
                v_d     = '0;
                frame_d = frame_q + FRAME_W'(1);
            end else begin
                v_d = v_q + Y_W'(1);
            end
        end
    end

    always_comb begin
        raw    = '0;
        raw.hs = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
        raw.vs = (v_ext >= VS_BEGIN) && (v_ext < VS_END);
        raw.de = de_raw;
        raw.x  = de_raw ? h_q : '0;
        raw.y  = de_raw ? v_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_q       <= '0;
            line_q        <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            // Strobes decode the pre-edge counters and last one clk only.
            line_q        <= pix_en && (h_q == '0);
            frame_start_q <= pix_en && (h_q == '0) && (v_q == '0);
            vblank_q      <= pix_en && (h_q == '0) && (v_ext == V_ACTIVE);
            if (pix_en) begin
                h_q     <= h_d;
                v_q     <= v_d;
                frame_q <= frame_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PIPE_DLY; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (pix_en) begin
            pipe_q[0] <= raw;
            for (int unsigned i = 1; i < PIPE_DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign hsync        = pipe_q[PIPE_DLY-1].hs ? HS_POL : ~HS_POL;
    assign vsync        = pipe_q[PIPE_DLY-1].vs ? VS_POL : ~VS_POL;
    assign de           = pipe_q[PIPE_DLY-1].de;
    assign x            = pipe_q[PIPE_DLY-1].x;
    assign y            = pipe_q[PIPE_DLY-1].y;
    assign line_start   = line_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_q;
    assign frame_count  = frame_q;

endmodule
